// File: rtl/column_window_9.sv
// Streaming 9-row column generator: buffers the last 8 image rows and, for every
// pixel from row 8 onward, presents the 9 vertically aligned pixels oldest-first.
module column_window_9 #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       done_i,
    input  logic       sof_i,
    input  logic [7:0] pix_i,
    output logic       done_o,
    output logic       last_o,
    output logic [7:0] S1,
    output logic [7:0] S2,
    output logic [7:0] S3,
    output logic [7:0] S4,
    output logic [7:0] S5,
    output logic [7:0] S6,
    output logic [7:0] S7,
    output logic [7:0] S8,
    output logic [7:0] S9
);

    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    localparam logic [CW-1:0] COL_LAST  = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(HEIGHT - 1);
    localparam logic [RW-1:0] ROW_FIRST = RW'(8);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [CW-1:0] col_eff;
    logic [RW-1:0] row_eff;
    logic          col_last;
    logic          row_last;

    logic [7:0] line_mem [0:7][0:WIDTH-1];
    logic [7:0] tap      [0:7];
    logic [7:0] col_q    [0:8];

    // A start-of-frame pixel is always position (0,0), whatever the counters say.
    always_comb begin
        col_eff  = sof_i ? '0 : col;
        row_eff  = sof_i ? '0 : row;
        col_last = (col_eff == COL_LAST);
        row_last = (row_eff == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            row <= '0;
        end else if (done_i) begin
            if (col_last) begin
                col <= '0;
                row <= row_last ? '0 : row_eff + RW'(1);
            end else begin
                col <= col_eff + CW'(1);
                row <= row_eff;
            end
        end
    end

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            tap[k] = line_mem[k][col_eff];
        end
    end

    // Shift each column down one buffer: reads see the old contents at this address.
    always_ff @(posedge clk) begin
        if (done_i) begin
            line_mem[0][col_eff] <= pix_i;
            for (int k = 1; k < 8; k++) begin
                line_mem[k][col_eff] <= tap[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_o <= 1'b0;
            last_o <= 1'b0;
            for (int k = 0; k < 9; k++) begin
                col_q[k] <= '0;
            end
        end else begin
            done_o <= done_i && (row_eff >= ROW_FIRST);
            last_o <= done_i && col_last && row_last;
            if (done_i) begin
                col_q[8] <= pix_i;
                for (int k = 1; k < 9; k++) begin
                    col_q[8-k] <= tap[k-1];
                end
            end
        end
    end

    assign S1 = col_q[0];
    assign S2 = col_q[1];
    assign S3 = col_q[2];
    assign S4 = col_q[3];
    assign S5 = col_q[4];
    assign S6 = col_q[5];
    assign S7 = col_q[6];
    assign S8 = col_q[7];
    assign S9 = col_q[8];

endmodule

// File: tb/tb_column_window_9.sv
// Directed bench for column_window_9 on a 4x12 image: reset, continuous and gapped
// streams, frame wrap, mid-frame resync and asynchronous reset.
module tb_column_window_9;

    localparam int W = 4;
    localparam int H = 12;

    logic       clk    = 1'b0;
    logic       rst    = 1'b0;
    logic       done_i = 1'b0;
    logic       sof_i  = 1'b0;
    logic [7:0] pix_i  = 8'h00;
    logic       done_o;
    logic       last_o;
    logic [7:0] S1, S2, S3, S4, S5, S6, S7, S8, S9;

    int          passCount  = 0;
    int          checkCount = 0;
    logic [71:0] heldS      = '0;
    bit          heldValid  = 1'b0;

    always #5 clk = ~clk;

    column_window_9 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk    (clk),
        .rst    (rst),
        .done_i (done_i),
        .sof_i  (sof_i),
        .pix_i  (pix_i),
        .done_o (done_o),
        .last_o (last_o),
        .S1     (S1),
        .S2     (S2),
        .S3     (S3),
        .S4     (S4),
        .S5     (S5),
        .S6     (S6),
        .S7     (S7),
        .S8     (S8),
        .S9     (S9)
    );

    function automatic logic [7:0] pixVal(input int r, input int c, input int rs, input int off);
        return 8'(r * rs + c + off);
    endfunction

    // Expected {S1..S9} for the column emitted after pixel (r,c), S1 = row r-8.
    function automatic logic [71:0] colVal(input int r, input int c, input int rs, input int off);
        logic [71:0] v;
        v = '0;
        for (int j = 0; j < 9; j++) begin
            v[71-8*j -: 8] = pixVal(r - 8 + j, c, rs, off);
        end
        return v;
    endfunction

    task automatic checkOutput(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input bit d, input bit s, input logic [7:0] p);
        done_i = d;
        sof_i  = s;
        pix_i  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " done_o"}, 72'(done_o), 72'(0));
        checkOutput({tag, " last_o"}, 72'(last_o), 72'(0));
        checkOutput({tag, " S"}, {S1, S2, S3, S4, S5, S6, S7, S8, S9}, 72'(0));
    endtask

    // Streams count pixels from (0,0), with optional random idle gaps before each.
    task automatic runPixels(input int count, input int rs, input int off,
                             input int maxGap, input bit firstSof);
        int r;
        int c;
        int gaps;
        for (int i = 0; i < count; i++) begin
            r    = i / W;
            c    = i % W;
            gaps = (maxGap > 0) ? int'($urandom_range(0, maxGap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                applyStimulus(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
                checkOutput($sformatf("gap done_o r%0d c%0d", r, c), 72'(done_o), 72'(0));
                checkOutput($sformatf("gap last_o r%0d c%0d", r, c), 72'(last_o), 72'(0));
                if (heldValid)
                    checkOutput($sformatf("gap hold r%0d c%0d", r, c),
                                {S1, S2, S3, S4, S5, S6, S7, S8, S9}, heldS);
            end
            applyStimulus(1'b1, firstSof && (i == 0), pixVal(r, c, rs, off));
            checkOutput($sformatf("done_o r%0d c%0d", r, c), 72'(done_o), 72'(r >= 8));
            checkOutput($sformatf("last_o r%0d c%0d", r, c), 72'(last_o),
                        72'((r == H - 1) && (c == W - 1)));
            if (r >= 8) begin
                heldS     = colVal(r, c, rs, off);
                heldValid = 1'b1;
                checkOutput($sformatf("S r%0d c%0d", r, c),
                            {S1, S2, S3, S4, S5, S6, S7, S8, S9}, heldS);
            end else begin
                heldValid = 1'b0;
            end
        end
    endtask

    initial begin
        // Held in reset while pixels toggle: nothing may leak out.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 8'($urandom));
            checkAllZero($sformatf("reset hold %0d", i));
        end
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 8'h55);
        checkAllZero("after release");
        applyStimulus(1'b0, 1'b1, 8'hAA);
        checkAllZero("sof without done");

        runPixels(W * H, 16, 0, 0, 1'b1);
        runPixels(W * H, 16, 0, 5, 1'b0);
        runPixels(W * H, 0, 8'hF0, 0, 1'b0);

        // Resync mid-frame at (10,2), then stream a distinguishable new frame.
        runPixels(10 * W + 2, 16, 0, 0, 1'b1);
        runPixels(9 * W + 2, 16, 4, 0, 1'b1);

        // Asynchronous reset between clock edges during row 9.
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("async reset");
        applyStimulus(1'b0, 1'b0, 8'h00);
        checkAllZero("async reset edge");
        rst       = 1'b1;
        heldValid = 1'b0;
        runPixels(W * H, 16, 0, 0, 1'b1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/column_window_9.md
Name: column_window_9

Overview:
- Streaming 9-row column generator for the 9x9 median filter datapath.
- Accepts one raster-order 8-bit pixel per valid cycle and buffers the last 8 image rows in line memories.
- For every pixel from row 8 onward, emits the 9 vertically aligned pixels of that column, oldest row first.
- Feeds the 9-input ascending sorter directly: S1..S9 map onto the sorter's S1..S9 and done_o drives its done_i.

Parameters:
WIDTH, 640, pixels per image row; legal range 2..4096
HEIGHT, 480, rows per frame; legal range 9..4096

Ports:
clk  in  1  single clock, all logic on rising edge
rst  in  1  asynchronous, active-low reset
done_i  in  1  input pixel valid (one pixel per asserted cycle)
sof_i  in  1  start of frame; qualified by done_i
pix_i  in  8  input pixel, raster order
done_o  out  1  column valid, drives sorter done_i
last_o  out  1  high with done_o for the final column of a frame
S1..S9  out  8 each  column pixels; S1 = row y-8, S9 = row y (current)

Behaviour:
- Reset (rst low, asynchronous):
  - col and row counters go to 0.
  - done_o, last_o and S1..S9 go to 0.
  - Line-memory contents are not cleared and are don't-care.
- Counters: col 0..WIDTH-1 and row 0..HEIGHT-1 advance only on done_i.
  - col wraps to 0 and row increments.
  - At col=WIDTH-1, row=HEIGHT-1 both wrap to 0.
- Line memories: 8 buffers of WIDTH x 8 bits, all sharing the col address.
  - On done_i at col c: buffer1[c] <= pix_i; buffer(k+1)[c] <= buffer(k)[c] (old value), for k=1..7.
  - Buffer k therefore holds row y-k.
  - Read-before-write at the same address.
- Output register, latency exactly 1 cycle after the done_i edge:
  - S9 <= pix_i; S(9-k) <= buffer(k)[c], for k=1..8.
  - done_o <= done_i && (row >= 8).
  - last_o <= done_i && row==HEIGHT-1 && col==WIDTH-1.
- Stall (done_i low): no counter or memory change; done_o=0, last_o=0; S1..S9 hold their previous values.
- sof_i && done_i:
  - The pixel is treated as col=0, row=0 regardless of the counter state; counters restart from it.
  - done_o for that pixel is 0.
  - sof_i without done_i is ignored.
- Frame boundary: buffers are not flushed between frames, but done_o stays low for rows 0..7 of every frame, so no output mixes data from two frames.
- Throughput: one column per cycle sustained; no backpressure input, so the downstream sorter must accept every done_o.
- Reset mid-frame: all outputs clear immediately; the next done_i pixel is col=0, row=0.

Test Plan:
1. Hold rst low, toggle clk and pix_i -> done_o=0, last_o=0, S1..S9=0x00. Release rst -> outputs stay 0 until qualifying input.
2. WIDTH=4, HEIGHT=12; continuous done_i; pix = row*16+col; sof_i on the first pixel.
   - The first 32 pixels give no done_o.
   - The cycle after pixel (8,0): done_o=1, S1=0x00, S2=0x10 ... S8=0x70, S9=0x80.
   - The cycle after pixel (9,2): S1=0x12, S9=0x92.
3. Same stream with random done_i gaps (0-5 idle cycles) -> S1..S9 sequence on done_o cycles identical to scenario 2; done_o=0 and S held during gaps.
4. Complete frame, then second frame with pix = 0xF0 + col.
   - The column after pixel (11,3): last_o=1, S1=0x33, S9=0xB3.
   - Next frame rows 0..7: no done_o.
   - Second frame row 8 col 0: S1..S9 all 0xF0.
5. sof_i with done_i at row 10, col 2 -> counters resync to (0,0); no done_o until 32 further pixels; the 33rd gives done_o with S9 = the new row-8 col-0 pixel.
6. Assert rst low mid-cycle during row 9 -> done_o, last_o, S1..S9 drop to 0 without waiting for a clock edge. Resume with sof_i -> behaviour matches scenario 2 from the start.
